// File: rtl/fb_rotator_pkg.sv
// fb_rotator_pkg: shared types and helpers for frame_buffer_rotator.
//   buf_state_t  per-buffer ownership state (FREE/DRAW/READY/DISP)
//   MAX_BUFS     largest supported buffer count
//   idx_w()      index width for a given buffer count (never below 1)
//   reset_state  ownership of buffer i out of reset (0=DISP, 1=DRAW, rest FREE)
package fb_rotator_pkg;

   typedef enum logic [1:0] {
      BUF_FREE  = 2'd0,
      BUF_DRAW  = 2'd1,
      BUF_READY = 2'd2,
      BUF_DISP  = 2'd3
   } buf_state_t;

   localparam int MAX_BUFS = 8;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic buf_state_t reset_state(input int i);
      return (i == 0) ? BUF_DISP : (i == 1) ? BUF_DRAW : BUF_FREE;
   endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync: brings the asynchronous vsync into the CLK domain and
// emits a one-cycle vs_event on the active edge.
//   CLK       system clock
//   rst       synchronous active-high reset, clears all flops
//   vsync     asynchronous vsync from the timing generator
//   vs_event  one-cycle pulse: falling edge (VS_ACTIVE_LOW=1) or rising edge
module vsync_edge_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter bit VS_ACTIVE_LOW = 1'b1
)(
   input  logic CLK,
   input  logic rst,
   input  logic vsync,
   output logic vs_event
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   cur;

   assign cur = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], vsync};
         prev_q <= cur;
      end
   end

   // Flops clear to 0, so an idle-high active-low vsync coming out of reset
   // looks like a rising edge and never produces a spurious event.
   assign vs_event = VS_ACTIVE_LOW ? (prev_q & ~cur) : (~prev_q & cur);

endmodule

// File: rtl/frame_buffer_rotator.sv
// frame_buffer_rotator: N-way frame-buffer ownership controller between the
// render core and the scan-out address mux.
//   CLK, rst    system clock, synchronous active-high reset
//   vsync       asynchronous vsync from the timing generator
//   swap_req    1-cycle pulse, renderer finished buffer draw_idx
//   draw_idx    buffer the renderer writes (valid while !draw_stall)
//   draw_stall  no buffer available for drawing
//   disp_idx    buffer scan-out reads
//   swap_ack    1-cycle pulse on the cycle disp_idx changes
//   frame_cnt   vs_event count, wraps
//   drop_cnt    superseded READY frames, saturating
// Build option: define SWAP_STATS_EN to enable drop_cnt; otherwise it is tied 0.
module frame_buffer_rotator
   import fb_rotator_pkg::*;
#(
   parameter int NUM_BUFS      = 3,
   parameter bit VS_ACTIVE_LOW = 1'b1,
   parameter bit BYPASS_VSYNC  = 1'b0,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 16,
   localparam int IDX_W        = idx_w(NUM_BUFS)
)(
   input  logic             CLK,
   input  logic             rst,
   input  logic             vsync,
   input  logic             swap_req,
   output logic [IDX_W-1:0] draw_idx,
   output logic             draw_stall,
   output logic [IDX_W-1:0] disp_idx,
   output logic             swap_ack,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   if (NUM_BUFS < 2 || NUM_BUFS > MAX_BUFS) begin : g_bad_bufs
      $error("frame_buffer_rotator: NUM_BUFS out of range");
   end

   buf_state_t       st     [NUM_BUFS];
   buf_state_t       st_nxt [NUM_BUFS];
   logic             has_draw, has_ready;
   logic [IDX_W-1:0] ready_idx;
   logic             vs_sync_event, vs_event;
   logic             accept, flip, alloc_done;

   vsync_edge_sync #(
      .SYNC_STAGES   (SYNC_STAGES),
      .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
   ) u_vs_sync (
      .CLK      (CLK),
      .rst      (rst),
      .vsync    (vsync),
      .vs_event (vs_sync_event)
   );

   assign vs_event = BYPASS_VSYNC ? 1'b1 : vs_sync_event;

   // Locate the DRAW/READY/DISP buffers; the invariant guarantees at most one each.
   always_comb begin
      has_draw  = 1'b0;
      has_ready = 1'b0;
      draw_idx  = '0;
      ready_idx = '0;
      disp_idx  = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (st[i] == BUF_DRAW)  begin has_draw  = 1'b1; draw_idx  = IDX_W'(i); end
         if (st[i] == BUF_READY) begin has_ready = 1'b1; ready_idx = IDX_W'(i); end
         if (st[i] == BUF_DISP)  disp_idx = IDX_W'(i);
      end
   end

   assign draw_stall = ~has_draw;
   assign accept     = swap_req & has_draw;
   // A same-cycle swap makes the just-finished buffer eligible for this flip.
   assign flip       = vs_event & (accept | has_ready);

   // Swap first, then flip, then refill the DRAW slot from the lowest FREE buffer.
   always_comb begin
      alloc_done = 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) st_nxt[i] = st[i];
      if (accept) begin
         if (has_ready) st_nxt[ready_idx] = BUF_FREE;
         st_nxt[draw_idx] = BUF_READY;
      end
      if (flip) begin
         st_nxt[disp_idx] = BUF_FREE;
         st_nxt[accept ? draw_idx : ready_idx] = BUF_DISP;
      end
      if (!has_draw || accept) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            if (!alloc_done && st_nxt[i] == BUF_FREE) begin
               st_nxt[i]  = BUF_DRAW;
               alloc_done = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         for (int i = 0; i < NUM_BUFS; i++) st[i] <= reset_state(i);
         swap_ack  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_BUFS; i++) st[i] <= st_nxt[i];
         swap_ack <= flip;
         if (vs_event) frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

`ifdef SWAP_STATS_EN
   logic drop_inc;
   assign drop_inc = accept & has_ready;

   always_ff @(posedge CLK) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop_inc && drop_cnt != {CNT_W{1'b1}})
         drop_cnt <= drop_cnt + CNT_W'(1);
   end
`else
   assign drop_cnt = '0;
`endif

endmodule
